// File: rtl/wand_bus_resolver.sv
// rtl/wand_bus_resolver.sv - wired-AND open-drain line resolver with deglitch, edges, arbitration and stuck detect
//
// Purpose:
//   Resolves a shared open-drain line from N_CH local drivers and one
//   asynchronous external level. The resolved level is synchronised,
//   deglitched by a FILT_LEN-cycle agreement filter, and used to derive
//   edge pulses, sticky per-channel arbitration-lost flags and a low-time
//   counter with a stuck-low flag.
//
// Optional feature:
//   WAND_BUS_STATS_EN - adds fall_cnt_o, a wrapping count of accepted falls.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   drv_i       in   N_CH    per-channel drive: 1 = release, 0 = pull low
//   ext_i       in   1       external line level, asynchronous
//   sample_i    in   1       arbitration sample strobe
//   lost_clr_i  in   1       clears all lost_o flags
//   line_o      out  1       filtered resolved line level
//   fall_o      out  1       pulse on accepted high->low
//   rise_o      out  1       pulse on accepted low->high
//   lost_o      out  N_CH    sticky arbitration-lost flags
//   low_cnt_o   out  CNT_W   cycles line_o has been low (saturating)
//   stuck_o     out  1       low_cnt_o >= STUCK_LIM
//   fall_cnt_o  out  CNT_W   accepted fall count (WAND_BUS_STATS_EN only)

module wand_bus_resolver #(
   parameter int N_CH      = 4,
   parameter int FILT_LEN  = 3,
   parameter int CNT_W     = 16,
   parameter int STUCK_LIM = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  drv_i,
   input  logic             ext_i,
   input  logic             sample_i,
   input  logic             lost_clr_i,
   output logic             line_o,
   output logic             fall_o,
   output logic             rise_o,
   output logic [N_CH-1:0]  lost_o,
   output logic [CNT_W-1:0] low_cnt_o,
   output logic             stuck_o
`ifdef WAND_BUS_STATS_EN
   ,
   output logic [CNT_W-1:0] fall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_HI     = 2'd0,
      ST_CHK_LO = 2'd1,
      ST_LO     = 2'd2,
      ST_CHK_HI = 2'd3
   } state_t;

   localparam logic [3:0]       FILT_LIM  = 4'(FILT_LEN);
   localparam logic [3:0]       FILT_ONE  = 4'd1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STUCK_VAL = CNT_W'(STUCK_LIM);

   state_t           state, state_nxt;
   logic [3:0]       filt_cnt, filt_cnt_nxt;
   logic             ext_meta, ext_s;
   logic             raw;
   logic             line_nxt;
   logic [N_CH-1:0]  lost_nxt;
   logic [CNT_W-1:0] low_cnt_nxt;

   // Two-flop synchroniser; resets to the released (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_meta <= 1'b1;
         ext_s    <= 1'b1;
      end else begin
         ext_meta <= ext_i;
         ext_s    <= ext_meta;
      end
   end

   // Wired-AND: any driver (local or external) at 0 pulls the line low.
   assign raw = (&drv_i) & ext_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_HI;
         filt_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         filt_cnt <= filt_cnt_nxt;
      end
   end

   // The CHK states count consecutive cycles of the opposite level; any
   // agreeing cycle aborts back to the settled state, so short glitches vanish.
   always_comb begin
      state_nxt    = state;
      filt_cnt_nxt = filt_cnt;
      case (state)
         ST_HI: begin
            if (!raw) begin
               if (FILT_LIM == FILT_ONE) begin
                  state_nxt    = ST_LO;
                  filt_cnt_nxt = 4'd0;
               end else begin
                  state_nxt    = ST_CHK_LO;
                  filt_cnt_nxt = FILT_ONE;
               end
            end
         end
         ST_CHK_LO: begin
            if (raw) begin
               state_nxt    = ST_HI;
               filt_cnt_nxt = 4'd0;
            end else if (filt_cnt + FILT_ONE == FILT_LIM) begin
               state_nxt    = ST_LO;
               filt_cnt_nxt = 4'd0;
            end else begin
               filt_cnt_nxt = filt_cnt + FILT_ONE;
            end
         end
         ST_LO: begin
            if (raw) begin
               if (FILT_LIM == FILT_ONE) begin
                  state_nxt    = ST_HI;
                  filt_cnt_nxt = 4'd0;
               end else begin
                  state_nxt    = ST_CHK_HI;
                  filt_cnt_nxt = FILT_ONE;
               end
            end
         end
         ST_CHK_HI: begin
            if (!raw) begin
               state_nxt    = ST_LO;
               filt_cnt_nxt = 4'd0;
            end else if (filt_cnt + FILT_ONE == FILT_LIM) begin
               state_nxt    = ST_HI;
               filt_cnt_nxt = 4'd0;
            end else begin
               filt_cnt_nxt = filt_cnt + FILT_ONE;
            end
         end
         default: begin
            state_nxt    = ST_HI;
            filt_cnt_nxt = 4'd0;
         end
      endcase
   end

   assign line_o   = (state == ST_HI) || (state == ST_CHK_LO);
   assign line_nxt = (state_nxt == ST_HI) || (state_nxt == ST_CHK_LO);

   // Flags set on a sample while another driver holds the line low; a set in
   // the same cycle as a clear survives because the OR is applied last.
   assign lost_nxt = (lost_clr_i ? '0 : lost_o) |
                     ((sample_i && !line_o) ? drv_i : '0);

   assign low_cnt_nxt = line_o              ? '0        :
                        (low_cnt_o == CNT_MAX) ? low_cnt_o :
                        low_cnt_o + CNT_ONE;

   // Edge pulses coincide with the first cycle of the new line_o level;
   // CHK_HI -> LO is not an edge because line_o never went high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fall_o    <= 1'b0;
         rise_o    <= 1'b0;
         lost_o    <= '0;
         low_cnt_o <= '0;
         stuck_o   <= 1'b0;
      end else begin
         fall_o    <= line_o & ~line_nxt;
         rise_o    <= ~line_o & line_nxt;
         lost_o    <= lost_nxt;
         low_cnt_o <= low_cnt_nxt;
         stuck_o   <= (low_cnt_nxt >= STUCK_VAL);
      end
   end

`ifdef WAND_BUS_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fall_cnt_o <= '0;
      end else if (fall_o) begin
         fall_cnt_o <= fall_cnt_o + CNT_ONE;
      end else if (lost_clr_i) begin
         fall_cnt_o <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_wand_bus_resolver.sv
// tb/tb_wand_bus_resolver.sv - randomized self-checking bench for wand_bus_resolver

module tb_wand_bus_resolver;

   localparam int N_CH     = 4;
   localparam int FILT_LEN = 3;
   localparam int LIM      = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  drv = 4'hF;
   logic        ext = 1'b1;
   logic        sample = 1'b0;
   logic        clr = 1'b0;

   logic        line_a, fall_a, rise_a, stuck_a;
   logic [3:0]  lost_a;
   logic [15:0] low_a;
   logic        line_b, fall_b, rise_b, stuck_b;
   logic [3:0]  lost_b;
   logic [3:0]  low_b;
`ifdef WAND_BUS_STATS_EN
   logic [15:0] fcnt_a;
   logic [3:0]  fcnt_b;
`endif

   wand_bus_resolver #(.N_CH(N_CH), .FILT_LEN(FILT_LEN), .CNT_W(16), .STUCK_LIM(LIM)) dut_a (
      .clk(clk), .rst_n(rst_n), .drv_i(drv), .ext_i(ext), .sample_i(sample),
      .lost_clr_i(clr), .line_o(line_a), .fall_o(fall_a), .rise_o(rise_a),
      .lost_o(lost_a), .low_cnt_o(low_a), .stuck_o(stuck_a)
`ifdef WAND_BUS_STATS_EN
      , .fall_cnt_o(fcnt_a)
`endif
   );

   wand_bus_resolver #(.N_CH(N_CH), .FILT_LEN(FILT_LEN), .CNT_W(4), .STUCK_LIM(LIM)) dut_b (
      .clk(clk), .rst_n(rst_n), .drv_i(drv), .ext_i(ext), .sample_i(sample),
      .lost_clr_i(clr), .line_o(line_b), .fall_o(fall_b), .rise_o(rise_b),
      .lost_o(lost_b), .low_cnt_o(low_b), .stuck_o(stuck_b)
`ifdef WAND_BUS_STATS_EN
      , .fall_cnt_o(fcnt_b)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state
   bit          m_meta, m_ext_s, m_line, m_fall, m_rise, m_stuck, m_stuck4;
   bit [3:0]    m_lost;
   int unsigned m_run, m_low, m_low4, m_fcnt;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_meta = 1; m_ext_s = 1; m_line = 1; m_run = 0;
      m_fall = 0; m_rise = 0; m_lost = 0;
      m_low = 0; m_low4 = 0; m_stuck = 0; m_stuck4 = 0; m_fcnt = 0;
   endtask

   // One clock edge of behaviour: the line flips once the wired-AND has
   // disagreed with it for FILT_LEN consecutive cycles.
   task automatic model_edge();
      bit raw, old_line;
      raw      = (&drv) & m_ext_s;
      old_line = m_line;
      if (m_fall) m_fcnt = m_fcnt + 1;
      else if (clr) m_fcnt = 0;
      m_ext_s = m_meta;
      m_meta  = ext;
      if (raw != m_line) m_run++;
      else m_run = 0;
      if (m_run == FILT_LEN) begin
         m_line = ~m_line;
         m_run  = 0;
      end
      m_fall = old_line && !m_line;
      m_rise = !old_line && m_line;
      m_lost = (clr ? 4'h0 : m_lost) | ((sample && !old_line) ? drv : 4'h0);
      if (old_line) begin
         m_low = 0; m_low4 = 0;
      end else begin
         if (m_low < 65535) m_low++;
         if (m_low4 < 15) m_low4++;
      end
      m_stuck  = (m_low >= LIM);
      m_stuck4 = (m_low4 >= LIM);
   endtask

   task automatic check_outputs();
      chk("line",   32'(line_a),  32'(m_line));
      chk("fall",   32'(fall_a),  32'(m_fall));
      chk("rise",   32'(rise_a),  32'(m_rise));
      chk("lost",   32'(lost_a),  32'(m_lost));
      chk("low",    32'(low_a),   m_low);
      chk("stuck",  32'(stuck_a), 32'(m_stuck));
      chk("line4",  32'(line_b),  32'(m_line));
      chk("fall4",  32'(fall_b),  32'(m_fall));
      chk("rise4",  32'(rise_b),  32'(m_rise));
      chk("lost4",  32'(lost_b),  32'(m_lost));
      chk("low4",   32'(low_b),   m_low4);
      chk("stuck4", 32'(stuck_b), 32'(m_stuck4));
`ifdef WAND_BUS_STATS_EN
      chk("fcnt",   32'(fcnt_a),  m_fcnt % 65536);
      chk("fcnt4",  32'(fcnt_b),  m_fcnt % 16);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      check_outputs();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      model_reset();
      #2;
      check_outputs();
      steps(2);
      rst_n = 1'b1;
      steps(3);

      // Local pull-low accepted after FILT_LEN cycles, released likewise.
      drv = 4'hE;
      steps(2);
      chk("t2_line_still_high", 32'(line_a), 32'd1);
      step();
      chk("t2_line_low", 32'(line_a), 32'd0);
      chk("t2_fall", 32'(fall_a), 32'd1);
      steps(4);
      drv = 4'hF;
      steps(3);
      chk("t2_rise", 32'(rise_a), 32'd1);
      steps(3);

      // Two-cycle glitches on drv_i and ext_i are rejected.
      drv = 4'hE; steps(2); drv = 4'hF; steps(4);
      ext = 1'b0; steps(2); ext = 1'b1; steps(6);
      chk("t3_line", 32'(line_a), 32'd1);

      // Arbitration loss with and without a simultaneous clear.
      drv = 4'hE; steps(4);
      drv = 4'h6; sample = 1'b1; step();
      chk("t4_lost", 32'(lost_a), 32'h6);
      sample = 1'b0; steps(2);
      drv = 4'h2; sample = 1'b1; clr = 1'b1; step();
      chk("t4_lost_clr", 32'(lost_a), 32'h2);
      sample = 1'b0; clr = 1'b1; step();
      clr = 1'b0; drv = 4'hF; steps(4);

      // Long external low: stuck flag and low-counter saturation.
      ext = 1'b0; steps(40);
      chk("t5_stuck", 32'(stuck_a), 32'd1);
      chk("t5_sat4", 32'(low_b), 32'd15);
      ext = 1'b1; steps(6);
      chk("t5_low_clr", 32'(low_a), 32'd0);

      // Asynchronous reset while the line is low, then re-qualification.
      drv = 4'h0; steps(12);
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      step();
      rst_n = 1'b1;
      steps(6);
      drv = 4'hF; steps(4);

      // Randomized traffic with occasional glitches and strobes.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0)
            drv = ($urandom_range(9) < 6) ? 4'hF : 4'($urandom_range(15));
         if ($urandom_range(9) == 0) ext = ~ext;
         sample = ($urandom_range(3) == 0);
         clr    = ($urandom_range(15) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
